// File: rtl/apb0_reg_slave.sv
// APB completer for apb0: read-only ID, byte-strobed scratch words and a sticky W1C
// event STATUS register, with programmable wait states and PSLVERR on illegal accesses.
`timescale 1ns/1ps
module apb0_reg_slave #(
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'h0A5B_0001,
   parameter bit          PRIV_ONLY   = 1'b0
) (
   input  logic        i_pclk,
   input  logic        i_prst,
   input  logic        i_psel,
   input  logic        i_penable,
   input  logic [31:0] i_paddr,
   input  logic        i_pwrite,
   input  logic [31:0] i_pwdata,
   input  logic [3:0]  i_pstrb,
   input  logic [2:0]  i_pprot,
   input  logic [7:0]  i_evt,
   output logic        o_pready,
   output logic        o_pslverr,
   output logic [31:0] o_prdata,
   output logic        o_irq
);
   localparam int unsigned IW       = $clog2(NUM_REGS);
   localparam logic [5:0]  STAT_IDX = 6'(NUM_REGS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt;
   logic [5:0]  r_idx;
   logic        r_write, r_err;
   logic [3:0]  r_strb;
   logic [31:0] r_wdata;
   logic [31:0] r_bank [NUM_REGS];
   logic [7:0]  r_status;
   logic        r_pready, r_pslverr, r_irq;
   logic [31:0] r_prdata;

   logic        w_setup, w_access, w_live_err;
   logic        w_enter_done, w_commit, w_rd_err, w_rd_write;
   logic [5:0]  w_rd_idx;
   logic [31:0] w_rdata;
   logic [7:0]  w_clr;
   logic        w_unused;

   assign w_setup    = i_psel & ~i_penable;
   assign w_access   = i_psel & i_penable;
   assign w_live_err = ({26'd0, i_paddr[7:2]} >= NUM_REGS)
                     | (i_pwrite & (i_paddr[7:2] == '0))
                     | (PRIV_ONLY & ~i_pprot[0]);
   assign w_unused   = ^{i_paddr[31:8], i_paddr[1:0], i_pprot[2:1]};

   always_ff @(posedge i_pclk) begin
      if (i_prst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_setup)
            r_cnt <= 4'(WAIT_CYCLES);
         else if (r_state == ST_WAIT && w_access)
            r_cnt <= r_cnt - 4'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_setup) w_state_nxt = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
         ST_WAIT: begin
            if (!i_psel)
               w_state_nxt = ST_IDLE;
            else if (i_penable && r_cnt == 4'd1)
               w_state_nxt = ST_DONE;
         end
         ST_DONE: if (!i_psel || i_penable) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A zero-wait transfer enters DONE on the setup edge, so decode the live bus there.
   always_comb begin
      w_enter_done = (r_state != ST_DONE) && (w_state_nxt == ST_DONE);
      w_commit     = (r_state == ST_DONE) & w_access & r_write & ~r_err;
      w_rd_idx     = (r_state == ST_IDLE) ? i_paddr[7:2] : r_idx;
      w_rd_write   = (r_state == ST_IDLE) ? i_pwrite : r_write;
      w_rd_err     = (r_state == ST_IDLE) ? w_live_err : r_err;
      w_rdata      = '0;
      if (!w_rd_err && !w_rd_write) begin
         if (w_rd_idx == '0)
            w_rdata = ID_VALUE;
         else if (w_rd_idx == STAT_IDX)
            w_rdata = {24'd0, r_status};
         else
            w_rdata = r_bank[w_rd_idx[IW-1:0]];
      end
      w_clr = '0;
      if (w_commit && r_idx == STAT_IDX && r_strb[0])
         w_clr = r_wdata[7:0];
   end

   always_ff @(posedge i_pclk) begin
      if (i_prst) begin
         r_idx   <= '0;
         r_write <= 1'b0;
         r_strb  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else if (r_state == ST_IDLE && w_setup) begin
         r_idx   <= i_paddr[7:2];
         r_write <= i_pwrite;
         r_strb  <= i_pstrb;
         r_wdata <= i_pwdata;
         r_err   <= w_live_err;
      end
   end

   always_ff @(posedge i_pclk) begin
      if (i_prst) begin
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_pready <= (w_state_nxt == ST_DONE);
         r_irq    <= |r_status;
         if (w_enter_done) begin
            r_pslverr <= w_rd_err;
            r_prdata  <= w_rdata;
         end else if (w_state_nxt != ST_DONE) begin
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
         end
      end
   end

   // Event set has priority over a coincident W1C clear.
   always_ff @(posedge i_pclk) begin
      if (i_prst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            r_bank[i] <= '0;
         r_status <= '0;
      end else begin
         r_status <= (r_status & ~w_clr) | i_evt;
         if (w_commit && r_idx != '0 && r_idx < STAT_IDX)
            for (int unsigned b = 0; b < 4; b++)
               if (r_strb[b])
                  r_bank[r_idx[IW-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
      end
   end

   assign o_pready  = r_pready;
   assign o_pslverr = r_pslverr;
   assign o_prdata  = r_prdata;
   assign o_irq     = r_irq;
endmodule
